// File: rtl/aes_uart_pkg.sv
// aes_uart_pkg: shared widths, frame constants and transmit FSM states for the AES UART datapath
package aes_uart_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTES_PER_BLK = 16;
  localparam int FRAME_BITS = 10;
  localparam int CHK_BYTES = BYTES_PER_BLK + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/aes_uart_tx_uart_byte_tx.sv
// uart_byte_tx: 8N1 byte transmitter; accepts the next byte on the final stop-bit cycle so frames abut
module uart_byte_tx
  import aes_uart_pkg::*;
#(
  parameter int BAUD_CNT_MAX = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       fin,
  output logic       tx
);
  localparam int CW = $clog2(BAUD_CNT_MAX + 1);
  tx_state_t st;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] b;
  logic wrap;
  assign wrap = cnt == CW'(BAUD_CNT_MAX - 1);
  assign byte_ready = st == IDLE || (st == STOP && wrap);
  assign fin = st == STOP && wrap && !byte_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      idx <= '0;
      b <= '0;
      tx <= 1'b1;
    end else begin
      cnt <= (st == IDLE || wrap) ? '0 : cnt + CW'(1);
      case (st)
        IDLE, STOP: begin
          if (byte_ready && byte_valid) begin
            b <= byte_data;
            st <= START;
            tx <= 1'b0;
          end else if (st == STOP && wrap) begin
            st <= IDLE;
            tx <= 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            st <= DATA;
            idx <= '0;
            tx <= b[0];
          end
        end
        DATA: begin
          if (wrap) begin
            idx <= idx + 3'd1;
            tx <= (idx == 3'd7) ? 1'b1 : b[idx + 3'd1];
            st <= (idx == 3'd7) ? STOP : DATA;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/aes_uart_tx.sv
// aes_uart_tx: sends a 128-bit block as 16 MSB-first 8N1 frames; AES_TX_CHECKSUM_EN appends an XOR frame
module aes_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int UART_BPS = 115200,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] blk_data,
  input  logic               blk_valid,
  output logic               blk_ready,
  output logic               tx,
  output logic               busy,
  output logic               done
);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
`ifdef AES_TX_CHECKSUM_EN
  localparam int NFR = CHK_BYTES;
`else
  localparam int NFR = BYTES_PER_BLK;
`endif
  logic [BLOCK_W-1:0] sh;
  logic [4:0] n;
  logic [7:0] byte_data;
  logic byte_valid, byte_ready, fin, acc, take;
  assign acc = blk_ready && blk_valid;
  // n counts frames still owed after the one in flight; the first byte bypasses the buffer
  assign byte_valid = blk_ready ? blk_valid : n != 5'd0;
  assign take = !blk_ready && byte_valid && byte_ready;
`ifdef AES_TX_CHECKSUM_EN
  logic [7:0] chk;
  assign byte_data = blk_ready ? blk_data[BLOCK_W-1 -: 8] : (n == 5'd1 ? chk : sh[BLOCK_W-1 -: 8]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk <= '0;
    else if (acc) chk <= blk_data[BLOCK_W-1 -: 8];
    else if (take) chk <= chk ^ byte_data;
  end
`else
  assign byte_data = blk_ready ? blk_data[BLOCK_W-1 -: 8] : sh[BLOCK_W-1 -: 8];
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      n <= '0;
      blk_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (acc) begin
        sh <= blk_data << 8;
        n <= 5'(NFR - 1);
        blk_ready <= 1'b0;
        busy <= 1'b1;
      end else if (take) begin
        sh <= sh << 8;
        n <= n - 5'd1;
      end
      if (fin) begin
        blk_ready <= 1'b1;
        busy <= 1'b0;
      end
    end
  end
  uart_byte_tx #(.BAUD_CNT_MAX(BAUD_CNT_MAX)) u_byte (
    .clk(clk),
    .rst_n(rst_n),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .fin(fin),
    .tx(tx)
  );
endmodule

// File: tb/tb_aes_uart_tx.sv
// tb_aes_uart_tx: directed bench at 16 clocks per bit; define AES_TX_CHECKSUM_EN to cover the checksum frame
module tb_aes_uart_tx;
`ifdef AES_TX_CHECKSUM_EN
  localparam int NF = 17;
`else
  localparam int NF = 16;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] blk_data = '0;
  logic blk_valid = 1'b0;
  logic blk_ready, tx, busy, done;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int dn;
  logic [7:0] got [0:16];
  logic [127:0] a, bk, c1, c2;

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  aes_uart_tx #(.UART_BPS(10), .CLK_FREQ(160)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .blk_data(blk_data),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [127:0] g, input logic [127:0] e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, g, e);
    end
  endtask

  // leaves the bench on the first negedge after the acceptance edge
  task automatic send(input logic [127:0] d);
    @(negedge clk);
    chk("ready_before_accept", {127'd0, blk_ready}, 128'd1);
    blk_data = d;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    chk("accept_state", {125'd0, blk_ready, busy, tx}, 128'b010);
  endtask

  // every bit must hold for all 16 cycles with done low throughout
  task automatic rx(input int f0, input int f1);
    logic [9:0] fr;
    logic v, ok;
    for (int f = f0; f <= f1; f++) begin
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        v = tx;
        for (int c = 0; c < 16; c++) begin
          if (tx !== v || done !== 1'b0) ok = 1'b0;
          @(negedge clk);
        end
        fr[i] = v;
      end
      chk($sformatf("frame%0d_shape", f), {125'd0, ok, fr[9], fr[0]}, 128'b110);
      got[f] = fr[8:1];
    end
  endtask

  task automatic check_block(input string tag, input logic [127:0] blk);
    logic [7:0] x;
    x = '0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), {120'd0, got[k]}, {120'd0, blk[127-8*k -: 8]});
      x = x ^ blk[127-8*k -: 8];
    end
`ifdef AES_TX_CHECKSUM_EN
    chk($sformatf("%s_checksum", tag), {120'd0, got[16]}, {120'd0, x});
`endif
  endtask

  initial begin
    a = 128'h00112233445566778899AABBCCDDEEFF;
    bk = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    c1 = 128'h0123456789ABCDEFFEDCBA9876543210;
    c2 = 128'hFFEEDDCCBBAA99887766554433221100;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("reset_idle", {124'd0, tx, blk_ready, busy, done}, 128'b1100);
    end

    send(a);
    rx(0, NF - 1);
    chk("a_done", {124'd0, done, blk_ready, busy, tx}, 128'b1101);
    for (int k = 0; k < 16; k++)
      chk($sformatf("a_byte%0d", k), {120'd0, got[k]}, {120'd0, 8'(k * 17)});
`ifdef AES_TX_CHECKSUM_EN
    chk("a_checksum", {120'd0, got[16]}, 128'h00);
`endif
    @(negedge clk);
    chk("a_done_one_cycle", {127'd0, done}, 128'd0);

    send(bk);
    blk_data = ~bk;
    blk_valid = 1'b1;
    rx(0, 7);
    chk("ignored_ready_low", {126'd0, blk_ready, busy}, 128'b01);
    blk_valid = 1'b0;
    blk_data = '0;
    rx(8, NF - 1);
    chk("ignored_done", {124'd0, done, blk_ready, busy, tx}, 128'b1101);
    check_block("ignored", bk);

    @(negedge clk);
    blk_data = c1;
    blk_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_accept", {126'd0, blk_ready, tx}, 128'b00);
    rx(0, NF - 1);
    chk("b2b_first_done", {126'd0, done, blk_ready}, 128'b11);
    check_block("b2b1", c1);
    blk_data = c2;
    @(negedge clk);
    blk_valid = 1'b0;
    chk("b2b_second_start", {125'd0, tx, blk_ready, done}, 128'b000);
    rx(0, NF - 1);
    chk("b2b_second_done", {126'd0, done, blk_ready}, 128'b11);
    check_block("b2b2", c2);

    send(a);
    rx(0, 4);
    repeat (72) @(negedge clk);
    chk("byte5_bit3_low", {127'd0, tx}, 128'd0);
    dn = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("reset_async", {124'd0, tx, blk_ready, busy, done}, 128'b1100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("reset_no_done", done_cnt, dn);
    chk("reset_idle_after", {124'd0, tx, blk_ready, busy, done}, 128'b1100);
    send(bk);
    rx(0, NF - 1);
    chk("post_reset_done", {124'd0, done, blk_ready, busy, tx}, 128'b1101);
    check_block("post_reset", bk);

`ifdef AES_TX_CHECKSUM_EN
    send({{15{8'h01}}, 8'h03});
    rx(0, 16);
    chk("chk_byte16", {120'd0, got[16]}, 128'h02);
    chk("chk_done_2720", {127'd0, done}, 128'd1);
`endif
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
